// File: rtl/mem_port_arbiter.sv
// Shares single-port ram1 between the RISC core (read/write) and the memory-dump port
// (read-only). Each access runs IDLE -> ISSUE -> [WAIT x RD_LAT] -> DONE -> IDLE. The dump
// port wins a contested grant once the CPU has taken STARVE_MAX grants in a row against it.
module mem_port_arbiter #(
  parameter int unsigned AW         = 8,
  parameter int unsigned DW         = 16,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dmp_req,
  input  logic [AW-1:0] dmp_addr,
  output logic          dmp_ack,
  output logic [DW-1:0] dmp_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout,
  output logic          busy,
  output logic          grant_owner
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);
  localparam logic [1:0] LastWait  = 2'(RD_LAT - 1);

  state_e        state_q, state_d;
  logic          owner_q, owner_d;      // 0 = CPU, 1 = dump
  logic          wr_q, wr_d;            // current grant is a CPU write
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] din_q, din_d;
  logic [1:0]    wait_cnt_q, wait_cnt_d;
  logic [3:0]    starve_q, starve_d;    // consecutive CPU grants while dump waits
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] dmp_rdata_q, dmp_rdata_d;

  // Next-state: arbitration in IDLE, read-latency count in WAIT, data capture on WAIT exit.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    din_d       = din_q;
    wait_cnt_d  = wait_cnt_q;
    starve_d    = starve_q;
    cpu_rdata_d = cpu_rdata_q;
    dmp_rdata_d = dmp_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (!dmp_req) starve_d = '0;
        if (cpu_req || dmp_req) begin
          state_d = StIssue;
          din_d   = cpu_wdata;
          if (cpu_req && !(dmp_req && (starve_q == StarveMax))) begin
            owner_d = 1'b0;
            wr_d    = cpu_we;
            addr_d  = cpu_addr;
            if (dmp_req && (starve_q != StarveMax)) starve_d = starve_q + 4'd1;
          end else begin
            owner_d  = 1'b1;
            wr_d     = 1'b0;
            addr_d   = dmp_addr;
            starve_d = '0;
          end
        end
      end
      StIssue: begin
        wait_cnt_d = '0;
        state_d    = wr_q ? StDone : StWait;
      end
      StWait: begin
        if (wait_cnt_q == LastWait) begin
          state_d = StDone;
          if (owner_q) dmp_rdata_d = mem_dout;
          else         cpu_rdata_d = mem_dout;
        end else begin
          wait_cnt_d = wait_cnt_q + 2'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; reset aborts any transaction and clears read data.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      owner_q     <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      din_q       <= '0;
      wait_cnt_q  <= '0;
      starve_q    <= '0;
      cpu_rdata_q <= '0;
      dmp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      wait_cnt_q  <= wait_cnt_d;
      starve_q    <= starve_d;
      cpu_rdata_q <= cpu_rdata_d;
      dmp_rdata_q <= dmp_rdata_d;
    end
  end

  // Outputs decode from registered state, so an asynchronous reset drops mem_we at once.
  always_comb begin
    busy        = (state_q != StIdle);
    mem_we      = (state_q == StIssue) && wr_q;
    cpu_ack     = (state_q == StDone) && !owner_q;
    dmp_ack     = (state_q == StDone) && owner_q;
    mem_addr    = addr_q;
    mem_din     = din_q;
    grant_owner = owner_q;
    cpu_rdata   = cpu_rdata_q;
    dmp_rdata   = dmp_rdata_q;
  end

endmodule
